// File: rtl/memory_reader.sv
// Sequential scanner for the opening-register memory: walks every index once per start
// and streams each stored record (optionally skipping empty slots) over valid/ready.
module memory_reader #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 17,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              skip_zero,
    output logic [ADDR_W-1:0] mem_idx,
    output logic              mem_enable,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] READ   = 2'd1;
    localparam logic [1:0] EMIT   = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] data_q;
    logic              skip_q;
    logic              skip_rec;

    // An empty slot in skip mode is consumed without ever raising out_valid.
    assign skip_rec = skip_q && (data_q == '0);

    // Every output is a pure function of registered state, so out_ready never reaches out_valid.
    assign mem_idx    = ptr;
    assign mem_enable = (state == READ);
    assign mem_wr     = 1'b0;
    assign out_valid  = (state == EMIT) && !skip_rec;
    assign out_data   = data_q;
    assign out_idx    = ptr;
    assign busy       = (state != IDLE);
    assign done       = (state == FINISH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            ptr    <= '0;
            data_q <= '0;
            skip_q <= 1'b0;
            count  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every branch sees pre-edge values of ptr/count.
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= READ;
                        ptr    <= '0;
                        count  <= '0;
                        skip_q <= skip_zero;
                    end
                end
                READ: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        data_q <= mem_rdata;
                        state  <= EMIT;
                    end
                end
                EMIT: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (skip_rec || out_ready) begin
                        if (!skip_rec) begin
                            count <= count + 1'b1;
                        end
                        if (ptr == LAST_IDX) begin
                            state <= FINISH;
                        end else begin
                            ptr   <= ptr + 1'b1;
                            state <= READ;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
